// File: rtl/ahb_lite_master_if.sv
// AHB-Lite master port bundle.
// master modport: drives address/control/write-data, receives HRDATA/HREADY/HRESP.
// slave modport:  the mirror image, for a slave model or bus fabric.
interface ahb_lite_master_if;
  logic [31:0] m_HADDR;
  logic        m_HWRITE;
  logic [1:0]  m_HTRANS;
  logic [31:0] m_HWDATA;
  logic [2:0]  m_HSIZE;
  logic [2:0]  m_HBURST;
  logic [3:0]  m_HPROT;
  logic [31:0] m_HRDATA;
  logic        m_HREADY;
  logic        m_HRESP;

  modport master (
    output m_HADDR, m_HWRITE, m_HTRANS, m_HWDATA, m_HSIZE, m_HBURST, m_HPROT,
    input  m_HRDATA, m_HREADY, m_HRESP
  );

  modport slave (
    input  m_HADDR, m_HWRITE, m_HTRANS, m_HWDATA, m_HSIZE, m_HBURST, m_HPROT,
    output m_HRDATA, m_HREADY, m_HRESP
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Bridges the core's single-outstanding request interface onto an AHB-Lite master port.
// Each request runs through an address phase, a data phase, and a one-cycle response
// pulse; wait states, two-cycle ERROR responses and a hung-slave watchdog are handled.
// All bus and core-side outputs are registered.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   addr/write/wdata  request, held by the core until ready
//   transfer          00 IDLE, 01 BUSY (no request), 10 NONSEQ, 11 SEQ
//   rdata/ready/err   completion: one-cycle ready pulse, err=1 on bus error or timeout
//   HTRANS            copy of bus HTRANS for core status
//   bus               AHB-Lite master port (ahb_lite_master_if.master)
module ahb_lite_master #(
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               addr,
  input  logic                      write,
  input  logic [31:0]               wdata,
  input  logic [1:0]                transfer,
  output logic [31:0]               rdata,
  output logic                      ready,
  output logic [1:0]                HTRANS,
  output logic                      err,
  ahb_lite_master_if.master         bus
);

  localparam int unsigned WdWidth = $clog2(TIMEOUT) + 1;
  localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAddr = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StErr  = 3'd3;
  localparam logic [2:0] StResp = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [WdWidth-1:0] wd_q, wd_d;
  logic [31:0]        haddr_q, haddr_d;
  logic               hwrite_q, hwrite_d;
  logic [1:0]         htrans_q, htrans_d;
  logic [31:0]        hwdata_q, hwdata_d;
  logic [31:0]        req_wdata_q, req_wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;

  logic stall;
  logic wd_expire;

  assign stall     = ~bus.m_HREADY;
  // Fires on the stall cycle that would bring the count to TIMEOUT.
  assign wd_expire = stall && (wd_q == WdLast);

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    htrans_d    = htrans_q;
    hwdata_d    = hwdata_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    err_d       = err_q;

    case (state_q)
      StIdle: begin
        if (transfer[1]) begin
          haddr_d     = addr;
          hwrite_d    = write;
          htrans_d    = transfer;
          req_wdata_d = wdata;
          wd_d        = '0;
          state_d     = StAddr;
        end
      end

      StAddr: begin
        if (bus.m_HREADY) begin
          htrans_d = 2'b00;
          hwdata_d = req_wdata_q;
          wd_d     = '0;
          state_d  = StData;
        end else if (wd_expire) begin
          // Withdraw the pending address phase to recover from a hung slave.
          htrans_d = 2'b00;
          wd_d     = '0;
          ready_d  = 1'b1;
          err_d    = 1'b1;
          rdata_d  = '0;
          state_d  = StResp;
        end else begin
          wd_d = wd_q + WdWidth'(1);
        end
      end

      StData: begin
        if (bus.m_HREADY) begin
          wd_d    = '0;
          ready_d = 1'b1;
          state_d = StResp;
          if (bus.m_HRESP) begin
            // Single-cycle ERROR is not legal AHB; still report it as an error.
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            err_d = 1'b0;
            if (!hwrite_q) begin
              rdata_d = bus.m_HRDATA;
            end
          end
        end else if (wd_expire) begin
          wd_d    = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else begin
          wd_d = wd_q + WdWidth'(1);
          if (bus.m_HRESP) begin
            state_d = StErr;
          end
        end
      end

      StErr: begin
        if (bus.m_HREADY) begin
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end
      end

      // The core still presents the finished request here, so transfer is ignored.
      StResp: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wd_q        <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      htrans_q    <= 2'b00;
      hwdata_q    <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      htrans_q    <= htrans_d;
      hwdata_q    <= hwdata_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  assign bus.m_HADDR  = haddr_q;
  assign bus.m_HWRITE = hwrite_q;
  assign bus.m_HTRANS = htrans_q;
  assign bus.m_HWDATA = hwdata_q;
  assign bus.m_HSIZE  = 3'b010;
  assign bus.m_HBURST = 3'b001;
  assign bus.m_HPROT  = HPROT_VAL;

  assign HTRANS = htrans_q;
  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
module tb_ahb_lite_master;

  localparam int unsigned Tmo = 4;
  localparam int KOk  = 0;
  localparam int KErr = 1;
  localparam int KTo  = 2;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [1:0]  trans;
    int          aw;     // ADDR-phase stall cycles
    int          dw;     // DATA-phase stall cycles before the outcome
    int          kind;
    logic [31:0] hrdata;
  } txn_t;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        write;
  logic [31:0] wdata;
  logic [1:0]  transfer;
  logic [31:0] rdata;
  logic        ready;
  logic [1:0]  HTRANS;
  logic        err;

  ahb_lite_master_if bus ();

  ahb_lite_master #(
    .TIMEOUT   (Tmo),
    .HPROT_VAL (4'b0011)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .write    (write),
    .wdata    (wdata),
    .transfer (transfer),
    .rdata    (rdata),
    .ready    (ready),
    .HTRANS   (HTRANS),
    .err      (err),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: architectural values expected on the outputs this cycle.
  logic [31:0] m_haddr = '0;
  logic        m_hwrite = 1'b0;
  logic [31:0] m_hwdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic [1:0]  e_htrans = 2'b00;
  logic        e_ready = 1'b0;
  logic        e_err_chk = 1'b1;
  logic        after_rst = 1'b1;

  int          rdy_cyc[$];
  logic [31:0] rdy_data[$];
  logic        rdy_err[$];
  logic [1:0]  ht_seq[$];
  logic [1:0]  prev_ht = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_HTRANS", 32'(bus.m_HTRANS), 32'(e_htrans));
      chk("HTRANS",   32'(HTRANS),       32'(e_htrans));
      chk("ready",    32'(ready),        32'(e_ready));
      chk("m_HADDR",  bus.m_HADDR,       m_haddr);
      chk("m_HWRITE", 32'(bus.m_HWRITE), 32'(m_hwrite));
      chk("m_HWDATA", bus.m_HWDATA,      m_hwdata);
      chk("rdata",    rdata,             m_rdata);
      if (e_err_chk) chk("err", 32'(err), 32'(m_err));
      chk("m_HSIZE",  32'(bus.m_HSIZE),  32'h2);
      chk("m_HBURST", 32'(bus.m_HBURST), 32'h1);
      chk("m_HPROT",  32'(bus.m_HPROT),  32'h3);
      if (ready === 1'b1) begin
        rdy_cyc.push_back(cyc);
        rdy_data.push_back(rdata);
        rdy_err.push_back(err);
      end
      if (bus.m_HTRANS !== 2'b00 && prev_ht === 2'b00) ht_seq.push_back(bus.m_HTRANS);
      prev_ht <= bus.m_HTRANS;
    end
  end

  // Apply one cycle of inputs and expectations, then advance to the next cycle.
  task automatic step(input logic r, input logic [1:0] tr_in, input logic [31:0] a,
                      input logic w, input logic [31:0] wd, input logic hr,
                      input logic hresp, input logic [31:0] hrd, input logic [1:0] eht,
                      input logic erdy);
    rst          = r;
    transfer     = tr_in;
    addr         = a;
    write        = w;
    wdata        = wd;
    bus.m_HREADY = hr;
    bus.m_HRESP  = hresp;
    bus.m_HRDATA = hrd;
    e_htrans     = eht;
    e_ready      = erdy;
    e_err_chk    = erdy || after_rst;
    @(posedge clk);
    #1;
    after_rst = r;
    if (r) begin
      m_haddr  = '0;
      m_hwrite = 1'b0;
      m_hwdata = '0;
      m_rdata  = '0;
      m_err    = 1'b0;
    end
  endtask

  task automatic idle(input int n, input logic [1:0] tr_in);
    for (int i = 0; i < n; i++)
      step(1'b0, tr_in, 32'h7777_0000 + 32'(i), 1'b1, 32'h6666_0000, 1'b1, 1'b0,
           32'hFFFF_0000, 2'b00, 1'b0);
  endtask

  // Timeline from the spec: request at c=0, ADDR from c=1, DATA from td, ready at tr.
  task automatic run_txn(input txn_t t, input int rst_off);
    bit   to_addr;
    int   td, te, tr;
    logic hr, hresp, r;
    logic [31:0] hrd;
    logic [1:0]  eht;
    to_addr = (t.kind == KTo) && (t.aw >= int'(Tmo));
    td = 2 + t.aw;
    te = td + t.dw;
    if (to_addr)           tr = 1 + int'(Tmo);
    else if (t.kind == KOk)  tr = td + t.dw + 1;
    else if (t.kind == KErr) tr = te + 2;
    else                   tr = td + int'(Tmo);
    for (int c = 0; c <= tr; c++) begin
      hr = 1'b1; hresp = 1'b0; hrd = 32'hA5A5_0000 | 32'(c); eht = 2'b00;
      if (c >= 1) begin
        m_haddr  = t.addr;
        m_hwrite = t.write;
      end
      if (!to_addr && c >= td) m_hwdata = t.wdata;
      if (c >= 1 && c < (to_addr ? tr : td)) eht = t.trans;
      if (c >= 1 && c < tr) begin
        if (to_addr) hr = 1'b0;
        else if (c < td) hr = (c > t.aw);
        else if (t.kind == KOk) begin
          hr = (c >= td + t.dw);
          if (hr) hrd = t.hrdata;
        end else if (t.kind == KErr) begin
          hr    = (c == te + 1);
          hresp = (c >= te);
        end else hr = 1'b0;
      end
      if (c == tr) begin
        if (t.kind != KOk) m_rdata = '0;
        else if (!t.write) m_rdata = t.hrdata;
        m_err = (t.kind != KOk);
      end
      r = (rst_off >= 0) && (c == rst_off);
      step(r, t.trans, t.addr, t.write, t.wdata, hr, hresp, hrd, eht, (c == tr));
      if (r) return;
    end
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                              input logic [1:0] tr, input int aw, input int dw,
                              input int kind, input logic [31:0] hrd);
    txn_t t;
    t.addr = a; t.write = w; t.wdata = wd; t.trans = tr;
    t.aw = aw; t.dw = dw; t.kind = kind; t.hrdata = hrd;
    return t;
  endfunction

  int c0;
  int n0;

  initial begin
    rst = 1'b1; transfer = 2'b00; addr = '0; write = 1'b0; wdata = '0;
    bus.m_HREADY = 1'b1; bus.m_HRESP = 1'b0; bus.m_HRDATA = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_m_HTRANS", 32'(bus.m_HTRANS), 32'h0);
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_rdata", rdata, 32'h0);

    // Reset and request together: reset wins, nothing issued.
    step(1'b1, 2'b10, 32'h5555_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    idle(2, 2'b00);
    // BUSY is not a request.
    idle(2, 2'b01);

    // Read, zero wait.
    c0 = cyc;
    run_txn(mk(32'h2000_0010, 1'b0, 32'h0101_0101, 2'b10, 0, 0, KOk, 32'hDEAD_BEEF), -1);
    chk("rd_ready_cycle", 32'(rdy_cyc[$]), 32'(c0 + 3));
    chk("rd_rdata", rdy_data[$], 32'hDEAD_BEEF);
    chk("rd_err", 32'(rdy_err[$]), 32'h0);
    chk("rd_htrans", 32'(ht_seq[$]), 32'h2);
    idle(1, 2'b00);

    // Write, two DATA wait states; rdata keeps the previous read value.
    c0 = cyc;
    run_txn(mk(32'h2000_0020, 1'b1, 32'h1234_5678, 2'b10, 0, 2, KOk, 32'h0BAD_0BAD), -1);
    chk("wr_ready_cycle", 32'(rdy_cyc[$]), 32'(c0 + 5));
    chk("wr_rdata_kept", rdy_data[$], 32'hDEAD_BEEF);

    // Read with one ADDR and one DATA wait state, issued straight after.
    c0 = cyc;
    run_txn(mk(32'h2000_0030, 1'b0, 32'h0, 2'b10, 1, 1, KOk, 32'h0BAD_F00D), -1);
    chk("rd2_ready_cycle", 32'(rdy_cyc[$]), 32'(c0 + 5));
    idle(1, 2'b00);

    // Two-cycle ERROR response.
    c0 = cyc;
    run_txn(mk(32'h4000_0000, 1'b0, 32'h0, 2'b10, 0, 0, KErr, 32'h0), -1);
    chk("err_ready_cycle", 32'(rdy_cyc[$]), 32'(c0 + 4));
    chk("err_flag", 32'(rdy_err[$]), 32'h1);
    chk("err_rdata", rdy_data[$], 32'h0);
    idle(1, 2'b00);

    // Successful read clears err.
    run_txn(mk(32'h2000_0040, 1'b0, 32'h0, 2'b10, 0, 0, KOk, 32'h1111_2222), -1);
    chk("ok_after_err", 32'(rdy_err[$]), 32'h0);

    // Watchdog in DATA, then in ADDR.
    c0 = cyc;
    run_txn(mk(32'h5000_0000, 1'b0, 32'h0, 2'b10, 0, 0, KTo, 32'h0), -1);
    chk("wd_data_cycle", 32'(rdy_cyc[$]), 32'(c0 + 6));
    chk("wd_data_err", 32'(rdy_err[$]), 32'h1);
    idle(2, 2'b00);
    c0 = cyc;
    run_txn(mk(32'h5000_0004, 1'b1, 32'h9999_9999, 2'b10, 4, 0, KTo, 32'h0), -1);
    chk("wd_addr_cycle", 32'(rdy_cyc[$]), 32'(c0 + 5));
    idle(2, 2'b00);

    // Back-to-back 8-beat sequence.
    n0 = rdy_cyc.size();
    for (int i = 0; i < 8; i++)
      run_txn(mk(32'h100 + 32'(4 * i), 1'b0, 32'h0, (i == 0) ? 2'b10 : 2'b11, 0, 0, KOk,
                 32'hC0DE_0000 + 32'(i)), -1);
    chk("b2b_count", 32'(rdy_cyc.size() - n0), 32'd8);
    for (int i = 1; i < 8; i++)
      chk("b2b_spacing", 32'(rdy_cyc[n0 + i] - rdy_cyc[n0 + i - 1]), 32'd4);
    chk("b2b_first_htrans", 32'(ht_seq[ht_seq.size() - 8]), 32'h2);
    for (int i = 1; i < 8; i++)
      chk("b2b_seq_htrans", 32'(ht_seq[ht_seq.size() - 8 + i]), 32'h3);
    idle(1, 2'b00);

    // Reset while in DATA: no ready, then a fresh request completes.
    n0 = rdy_cyc.size();
    run_txn(mk(32'h6000_0000, 1'b0, 32'h4444_4444, 2'b10, 0, 3, KOk, 32'h0), 3);
    idle(4, 2'b00);
    chk("rst_no_ready", 32'(rdy_cyc.size()), 32'(n0));
    c0 = cyc;
    run_txn(mk(32'h3000_0000, 1'b0, 32'h0, 2'b10, 0, 0, KOk, 32'hCAFE_0001), -1);
    chk("post_rst_cycle", 32'(rdy_cyc[$]), 32'(c0 + 3));
    chk("post_rst_rdata", rdy_data[$], 32'hCAFE_0001);
    idle(2, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
